vga_pattern_gen: RTL and testbench
==================================

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel tick (>=1)
- COLOR_W, 2, bits per colour channel
- SYNC_POL, 0, asserted sync level (0 = active-low)

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, system clock (50 MHz nominal)
- rst_n, in, 1, asynchronous active-low reset
- mode, in, 2, pattern select: 0 black, 1 colour bars, 2 checkerboard, 3 scrolling bars
- pixel_en, out, 1, one-clk strobe per pixel tick
- vga_sync_h, out, 1, horizontal sync
- vga_sync_v, out, 1, vertical sync
- vga_de, out, 1, active-video flag
- vga_rgb, out, 3*COLOR_W, {R,G,B}, MSB-first
- pix_x, out, 11, column of current output pixel
- pix_y, out, 10, row of current output pixel
- frame_start, out, 1, one-clk pulse at first pixel of each frame

Function
REQ-003 Divider: div_cnt SHALL count 0..CLK_DIV-1 on every clk; pixel_en SHALL be registered, high for exactly one clk when div_cnt wraps (period CLK_DIV clks; CLK_DIV=1 gives pixel_en constantly high).
REQ-004 h_cnt SHALL advance only when pixel_en=1, wrapping at H_TOTAL-1 to 0, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-005 v_cnt SHALL advance only when pixel_en=1 and h_cnt=H_TOTAL-1, wrapping at V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-006 On each pixel_en clk, outputs SHALL be registered from the pre-advance counters: all outputs mutually aligned, one tick of latency behind the counters.
REQ-007 Sync SHALL be asserted (level SYNC_POL) iff h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vertical sync uses the same rule on v_cnt.
REQ-008 vga_de SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; when vga_de=0, vga_rgb SHALL be 0.
REQ-009 pix_x and pix_y SHALL equal the h_cnt and v_cnt from which the current outputs were derived.
REQ-010 frame_start SHALL pulse for one clk on the pixel_en clk with h_cnt=0 and v_cnt=0.
REQ-011 Mode latch: mode SHALL be sampled into mode_q only at the frame_start clk; mid-frame mode changes take effect at the next frame.
REQ-012 Bars: BAR_W = H_ACTIVE/8; b = min(x/BAR_W, 7); each channel is all-ones if its bit is set (R=b[2], G=b[1], B=b[0]), else zero.
REQ-013 Checkerboard: white (all ones) if x[5]^y[5] is 1, else black.
REQ-014 Scroll: offset SHALL increment by 1 at each frame_start, wrapping H_ACTIVE-1 to 0; the mode 1 rule is applied with x' = (x+offset) mod H_ACTIVE.
REQ-015 Arithmetic SHALL be unsigned; x+offset SHALL be computed with one extra bit before the modulo so no overflow is lost.

Reset
REQ-016 While rst_n=0, asynchronously: div_cnt, h_cnt, v_cnt, offset and mode_q SHALL be 0; pixel_en, vga_de, vga_rgb, pix_x, pix_y and frame_start SHALL be 0; both syncs SHALL be at ~SYNC_POL.
REQ-017 After rst_n rises, the first pixel_en SHALL occur CLK_DIV clks later, and the first frame_start on that same clk.
REQ-018 A reset asserted mid-line or mid-frame SHALL abort the frame with no partial-state retention.

Verification
REQ-019 Defaults, mode=0: hsync low for 192 clks in every 1600-clk line; vsync low for 2 lines (3200 clks); frame_start period 840000 clks.
REQ-020 Defaults, mode=1: rgb=6'b000000 at pix_x=0..79, 6'b000011 at 80, 6'b111111 at 560..639, and 0 at pix_x=640 with vga_de=0.
REQ-021 mode=2: rgb=6'b000000 at (0,0), 6'b111111 at (32,0), 6'b000000 at (32,32).
REQ-022 mode switched 0->1 at line 100: rgb stays 0 until the next frame_start, then bars appear; mode=3 shifts the colour boundary at pix_x=80 left by 1 per frame (frame N boundary at 80-N), wrapping.
REQ-023 rst_n pulsed low at h_cnt=300, v_cnt=200: outputs immediately take reset values; after release, pix_x=0, pix_y=0 and frame_start occur CLK_DIV clks later.
REQ-024 Parameters CLK_DIV=1, H_ACTIVE=16, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, SYNC_POL=1: line=22 clks, frame=154 clks, syncs active-high for exactly 2 ticks and 1 line respectively.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: pixel-tick divider, h/v raster counters,
// and registered sync/DE/RGB for black, colour-bar, checkerboard and scrolling-bar patterns.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int COLOR_W  = 2,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  output logic                   pixel_en,
  output logic                   vga_sync_h,
  output logic                   vga_sync_v,
  output logic                   vga_de,
  output logic [3*COLOR_W-1:0]   vga_rgb,
  output logic [10:0]            pix_x,
  output logic [9:0]             pix_y,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int RGB_W   = 3 * COLOR_W;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] BAR_W   = 11'(H_ACTIVE / 8);
  localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [10:0]      h_cnt;
  logic [9:0]       v_cnt;
  logic [10:0]      offset;
  logic [10:0]      offset_inc;
  logic [1:0]       mode_q;
  logic [1:0]       eff_mode;
  logic [10:0]      eff_offset;
  logic             frame_first;
  logic             h_last;
  logic             v_last;
  logic             active;
  logic             hs_on;
  logic             vs_on;
  logic [11:0]      x_sum;
  logic [10:0]      x_scroll;
  logic [RGB_W-1:0] rgb_next;

  // Bar index is clamped so a width not divisible by 8 still ends on bar 7.
  function automatic logic [RGB_W-1:0] bar_color(input logic [10:0] x);
    logic [10:0] q;
    logic [2:0]  b;
    q = x / BAR_W;
    b = (q > 11'd7) ? 3'd7 : q[2:0];
    return {{COLOR_W{b[2]}}, {COLOR_W{b[1]}}, {COLOR_W{b[0]}}};
  endfunction

  assign tick = (div_cnt == DIV_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  assign frame_first = (h_cnt == 11'd0) && (v_cnt == 10'd0);
  assign h_last      = (h_cnt == H_LAST);
  assign v_last      = (v_cnt == V_LAST);
  assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_on       = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_on       = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign offset_inc  = (offset == H_ACT - 11'd1) ? 11'd0 : offset + 11'd1;

  // The first pixel of a frame already uses the newly latched mode and offset.
  assign eff_mode    = frame_first ? mode : mode_q;
  assign eff_offset  = frame_first ? offset_inc : offset;

  assign x_sum    = {1'b0, h_cnt} + {1'b0, eff_offset};
  assign x_scroll = (x_sum >= {1'b0, H_ACT}) ? 11'(x_sum - {1'b0, H_ACT}) : x_sum[10:0];

  // NOTE: rgb_next gets a default before the case so no latch is inferred.
  always_comb begin
    rgb_next = '0;
    if (active) begin
      case (eff_mode)
        2'd1:    rgb_next = bar_color(h_cnt);
        2'd2:    rgb_next = (h_cnt[5] ^ v_cnt[5]) ? '1 : '0;
        2'd3:    rgb_next = bar_color(x_scroll);
        default: rgb_next = '0;
      endcase
    end
  end

  // NOTE: there is no memory array here, so every register, outputs included, is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      offset      <= '0;
      mode_q      <= '0;
      pixel_en    <= 1'b0;
      frame_start <= 1'b0;
      vga_de      <= 1'b0;
      vga_rgb     <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      vga_sync_h  <= ~SYNC_POL;
      vga_sync_v  <= ~SYNC_POL;
    end else begin
      pixel_en    <= tick;
      frame_start <= tick && frame_first;
      if (tick) begin
        h_cnt <= h_last ? 11'd0 : h_cnt + 11'd1;
        if (h_last) begin
          v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
        end
        if (frame_first) begin
          mode_q <= mode;
          offset <= offset_inc;
        end
        vga_sync_h <= hs_on ? SYNC_POL : ~SYNC_POL;
        vga_sync_v <= vs_on ? SYNC_POL : ~SYNC_POL;
        vga_de     <= active;
        vga_rgb    <= rgb_next;
        pix_x      <= h_cnt;
        pix_y      <= v_cnt;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: a reduced raster (CLK_DIV=2) for patterns, sync,
// mode latching, scrolling and reset, plus a tiny CLK_DIV=1 active-high-sync instance.
module tb_vga_pattern_gen;

  // Instance A: 76 ticks/line (sync 66..73), 38 lines/frame (vsync 35..36), 5776 clks/frame.
  localparam int A_HT = 76;
  localparam int A_VT = 38;
  localparam int A_FRAME_CLKS = A_HT * A_VT * 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] mode_a = 2'd0;
  logic [1:0] mode_b = 2'd1;

  logic pixel_en_a, hs_a, vs_a, de_a, fs_a;
  logic [5:0] rgb_a;
  logic [10:0] pix_x_a;
  logic [9:0] pix_y_a;

  logic pixel_en_b, hs_b, vs_b, de_b, fs_b;
  logic [5:0] rgb_b;
  logic [10:0] pix_x_b;
  logic [9:0] pix_y_b;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] mode;
    int         x;
    int         y;
    logic [5:0] rgb;
    logic       de;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .H_ACTIVE(64), .H_FP(2), .H_SYNC(8), .H_BP(2),
    .V_ACTIVE(34), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(2), .COLOR_W(2), .SYNC_POL(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode_a),
    .pixel_en(pixel_en_a), .vga_sync_h(hs_a), .vga_sync_v(vs_a), .vga_de(de_a),
    .vga_rgb(rgb_a), .pix_x(pix_x_a), .pix_y(pix_y_a), .frame_start(fs_a)
  );

  vga_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .COLOR_W(2), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode_b),
    .pixel_en(pixel_en_b), .vga_sync_h(hs_b), .vga_sync_v(vs_b), .vga_de(de_b),
    .vga_rgb(rgb_b), .pix_x(pix_x_b), .pix_y(pix_y_b), .frame_start(fs_b)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] m, input int x, input int y,
                         input logic [5:0] rgb, input logic de, input logic hs, input logic vs);
    vec_t v;
    v.mode = m; v.x = x; v.y = y; v.rgb = rgb; v.de = de; v.hs = hs; v.vs = vs;
    vecs.push_back(v);
  endtask

  // Advance to the next tick whose outputs belong to pixel (x,y) of instance A.
  task automatic wait_pixel(input int x, input int y);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 2 * A_FRAME_CLKS + 100; n++) begin
      @(posedge clk);
      #1;
      if (pixel_en_a && pix_x_a == 11'(x) && pix_y_a == 10'(y)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_pixel(%0d,%0d): timed out", x, y);
    end
  endtask

  task automatic check_pix(input string name, input int x, input int y, input logic [5:0] rgb);
    wait_pixel(x, y);
    check(name, 32'(rgb_a), 32'(rgb));
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_pixel_en"}, 32'(pixel_en_a), 32'd0);
    check({tag, "_de"},       32'(de_a),       32'd0);
    check({tag, "_rgb"},      32'(rgb_a),      32'd0);
    check({tag, "_pix_x"},    32'(pix_x_a),    32'd0);
    check({tag, "_pix_y"},    32'(pix_y_a),    32'd0);
    check({tag, "_fs"},       32'(fs_a),       32'd0);
    check({tag, "_hs"},       32'(hs_a),       32'd1);
    check({tag, "_vs"},       32'(vs_a),       32'd1);
  endtask

  initial begin
    int hs_cnt, vs_cnt, pe_cnt, fs_cnt;
    bit found;

    // Mode 1 bars: BAR_W = 8, {R,G,B} each 2 bits.
    add_vec(2'd1,  0,  0, 6'b000000, 1'b1, 1'b1, 1'b1);
    add_vec(2'd1,  7,  0, 6'b000000, 1'b1, 1'b1, 1'b1);
    add_vec(2'd1,  8,  0, 6'b000011, 1'b1, 1'b1, 1'b1);
    add_vec(2'd1, 20,  3, 6'b001100, 1'b1, 1'b1, 1'b1);
    add_vec(2'd1, 63,  5, 6'b111111, 1'b1, 1'b1, 1'b1);
    add_vec(2'd1, 64,  5, 6'b000000, 1'b0, 1'b1, 1'b1);
    add_vec(2'd1, 66,  5, 6'b000000, 1'b0, 1'b0, 1'b1);
    add_vec(2'd1, 73,  5, 6'b000000, 1'b0, 1'b0, 1'b1);
    add_vec(2'd1, 74,  5, 6'b000000, 1'b0, 1'b1, 1'b1);
    add_vec(2'd1, 10, 33, 6'b000011, 1'b1, 1'b1, 1'b1);
    add_vec(2'd1, 10, 34, 6'b000000, 1'b0, 1'b1, 1'b1);
    add_vec(2'd1, 10, 35, 6'b000000, 1'b0, 1'b1, 1'b0);
    add_vec(2'd1, 10, 37, 6'b000000, 1'b0, 1'b1, 1'b1);
    // Mode 2 checkerboard on x[5]^y[5].
    add_vec(2'd2,  0,  0, 6'b000000, 1'b1, 1'b1, 1'b1);
    add_vec(2'd2, 32,  0, 6'b111111, 1'b1, 1'b1, 1'b1);
    add_vec(2'd2, 32, 32, 6'b000000, 1'b1, 1'b1, 1'b1);
    add_vec(2'd2,  0, 32, 6'b111111, 1'b1, 1'b1, 1'b1);
    add_vec(2'd2, 31, 33, 6'b111111, 1'b1, 1'b1, 1'b1);
    // Mode 0 black.
    add_vec(2'd0,  8,  0, 6'b000000, 1'b1, 1'b1, 1'b1);
    add_vec(2'd0, 40, 20, 6'b000000, 1'b1, 1'b1, 1'b1);

    #2 rst_n = 1'b0;
    #3;
    check_reset_a("rst0");
    check("rst0_b_hs", 32'(hs_b), 32'd0);
    check("rst0_b_vs", 32'(vs_b), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Frame timing of instance A over one full frame from a frame_start.
    found = 1'b0;
    for (int n = 0; n < A_FRAME_CLKS + 100 && !found; n++) begin
      @(posedge clk);
      #1;
      found = fs_a;
    end
    check("a_first_fs_found", 32'(found), 32'd1);
    hs_cnt = 0; vs_cnt = 0; pe_cnt = 0; fs_cnt = 0;
    for (int k = 1; k <= A_FRAME_CLKS; k++) begin
      @(posedge clk);
      #1;
      if (!hs_a) hs_cnt++;
      if (!vs_a) vs_cnt++;
      if (pixel_en_a) pe_cnt++;
      if (fs_a) fs_cnt++;
    end
    check("a_fs_period", 32'(fs_a), 32'd1);
    check("a_fs_count", 32'(fs_cnt), 32'd1);
    check("a_hs_low_clks", 32'(hs_cnt), 32'(16 * A_VT));
    check("a_vs_low_clks", 32'(vs_cnt), 32'(2 * A_HT * 2));
    check("a_pixel_en_count", 32'(pe_cnt), 32'(A_HT * A_VT));

    // Instance B: 22-clk line, 154-clk frame, active-high sync.
    found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(posedge clk);
      #1;
      found = fs_b;
    end
    check("b_first_fs_found", 32'(found), 32'd1);
    hs_cnt = 0; vs_cnt = 0; pe_cnt = 0; fs_cnt = 0;
    for (int k = 1; k <= 154; k++) begin
      @(posedge clk);
      #1;
      if (hs_b) hs_cnt++;
      if (vs_b) vs_cnt++;
      if (pixel_en_b) pe_cnt++;
      if (fs_b) fs_cnt++;
    end
    check("b_fs_period", 32'(fs_b), 32'd1);
    check("b_fs_count", 32'(fs_cnt), 32'd1);
    check("b_hs_high_clks", 32'(hs_cnt), 32'd14);
    check("b_vs_high_clks", 32'(vs_cnt), 32'd22);
    check("b_pixel_en_count", 32'(pe_cnt), 32'd154);

    // Table-driven pattern vectors; a mode change is applied on the last pixel of a frame.
    foreach (vecs[i]) begin
      if (vecs[i].mode != mode_a) begin
        wait_pixel(A_HT - 1, A_VT - 1);
        mode_a = vecs[i].mode;
      end
      wait_pixel(vecs[i].x, vecs[i].y);
      check($sformatf("vec%0d_rgb", i), 32'(rgb_a), 32'(vecs[i].rgb));
      check($sformatf("vec%0d_de", i),  32'(de_a),  32'(vecs[i].de));
      check($sformatf("vec%0d_hs", i),  32'(hs_a),  32'(vecs[i].hs));
      check($sformatf("vec%0d_vs", i),  32'(vs_a),  32'(vecs[i].vs));
    end

    // Mid-frame mode change only takes effect at the next frame.
    wait_pixel(0, 20);
    mode_a = 2'd1;
    check_pix("switch_same_frame", 8, 25, 6'b000000);
    check("switch_same_frame_de", 32'(de_a), 32'd1);
    check_pix("switch_next_frame", 8, 0, 6'b000011);

    // Mid-frame reset while hsync is asserted.
    wait_pixel(70, 20);
    check("pre_reset_hs", 32'(hs_a), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_a("rst1");
    mode_a = 2'd3;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_clk1_pixel_en", 32'(pixel_en_a), 32'd0);
    check("rel_clk1_fs", 32'(fs_a), 32'd0);
    @(posedge clk);
    #1;
    check("rel_clk2_pixel_en", 32'(pixel_en_a), 32'd1);
    check("rel_clk2_fs", 32'(fs_a), 32'd1);
    check("rel_clk2_pix_x", 32'(pix_x_a), 32'd0);
    check("rel_clk2_pix_y", 32'(pix_y_a), 32'd0);
    check("rel_clk2_rgb", 32'(rgb_a), 32'd0);
    @(posedge clk);
    #1;
    check("rel_clk3_fs", 32'(fs_a), 32'd0);
    check("rel_clk3_pixel_en", 32'(pixel_en_a), 32'd0);

    // Scrolling bars: frame N after reset uses offset N, boundary at x = 8-N.
    check_pix("scroll_f1_x6", 6, 0, 6'b000000);
    check_pix("scroll_f1_x7", 7, 0, 6'b000011);
    check_pix("scroll_f1_x62", 62, 1, 6'b111111);
    check_pix("scroll_f1_x63", 63, 1, 6'b000000);
    check_pix("scroll_f2_x5", 5, 0, 6'b000000);
    check_pix("scroll_f2_x6", 6, 0, 6'b000011);
    check_pix("scroll_f3_x4", 4, 0, 6'b000000);
    check_pix("scroll_f3_x5", 5, 0, 6'b000011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
